// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// vram_arbiter: shares one 16Kx8 asynchronous SRAM among video fetch, sprite fetch and CPU
// with fixed priority vid > spr > cpu. Define ARB_CPU_GUARD_EN to add the CPU starvation guard.
module vram_arbiter #(
  parameter int ACC_CYCLES   = 4,
  parameter int MAX_CPU_WAIT = 24
) (
  input  logic        clk40m,
  input  logic        cpu_rst_n,
  input  logic        vid_req,
  input  logic [13:0] vid_a,
  output logic        vid_ack,
  input  logic        spr_req,
  input  logic [13:0] spr_a,
  output logic        spr_ack,
  input  logic        vram_cpu_req,
  input  logic        vram_cpu_wr,
  input  logic [13:0] vram_cpu_a,
  input  logic [7:0]  vram_cpu_wdata,
  output logic        vram_cpu_ack,
  output logic [7:0]  mem_rdata,
  output logic [13:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_we_n,
  output logic        mem_oe_n,
  output logic [1:0]  grant_id
);

  localparam logic [1:0] ID_NONE  = 2'd0;
  localparam logic [1:0] ID_VID   = 2'd1;
  localparam logic [1:0] ID_SPR   = 2'd2;
  localparam logic [1:0] ID_CPU   = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  if (ACC_CYCLES < 2 || ACC_CYCLES > 15) begin : g_bad_acc
    $error("ACC_CYCLES must be within 2..15");
  end
  if (MAX_CPU_WAIT < 1 || MAX_CPU_WAIT > 31) begin : g_bad_wait
    $error("MAX_CPU_WAIT must fit the 5-bit wait counter");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [1:0]  r_grant_id;
  logic [13:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic [7:0]  r_mem_rdata;
  logic        r_mem_we_n;
  logic        r_mem_oe_n;
  logic        r_vid_ack;
  logic        r_spr_ack;
  logic        r_cpu_ack;

  logic        w_vid_elig;
  logic        w_spr_elig;
  logic        w_cpu_elig;
  logic        w_cpu_force;
  logic        w_cpu_grant;
  logic [1:0]  w_win;
  logic [13:0] w_win_a;
  logic        w_win_wr;
  logic [7:0]  w_win_wdata;

  // A requester whose ack is high this cycle still shows its finished request, so it sits out.
  always_comb begin
    w_vid_elig = vid_req & ~r_vid_ack;
    w_spr_elig = spr_req & ~r_spr_ack;
    w_cpu_elig = vram_cpu_req & ~r_cpu_ack;
    if (w_cpu_force) begin
      w_win = ID_CPU;
    end else if (w_vid_elig) begin
      w_win = ID_VID;
    end else if (w_spr_elig) begin
      w_win = ID_SPR;
    end else if (w_cpu_elig) begin
      w_win = ID_CPU;
    end else begin
      w_win = ID_NONE;
    end
  end

  assign w_cpu_grant = (r_state == ST_IDLE) && (w_win == ID_CPU);

  always_comb begin
    w_win_a     = 14'd0;
    w_win_wr    = 1'b0;
    w_win_wdata = 8'd0;
    case (w_win)
      ID_VID: w_win_a = vid_a;
      ID_SPR: w_win_a = spr_a;
      ID_CPU: begin
        w_win_a     = vram_cpu_a;
        w_win_wr    = vram_cpu_wr;
        w_win_wdata = vram_cpu_wdata;
      end
      default: w_win_a = 14'd0;
    endcase
  end

`ifdef ARB_CPU_GUARD_EN
  localparam logic [4:0] WAIT_MAX = 5'(MAX_CPU_WAIT);

  logic [4:0] r_cpu_wait;
  logic       w_cpu_busy;

  assign w_cpu_busy  = (r_state == ST_ACC) && (r_grant_id == ID_CPU);
  assign w_cpu_force = w_cpu_elig && (r_cpu_wait == WAIT_MAX);

  // Counts cycles a CPU request waits unserved; saturates so the override stays armed.
  always_ff @(posedge clk40m or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_cpu_wait <= 5'd0;
    end else if (!vram_cpu_req || w_cpu_grant) begin
      r_cpu_wait <= 5'd0;
    end else if (w_cpu_elig && !w_cpu_busy && (r_cpu_wait != WAIT_MAX)) begin
      r_cpu_wait <= r_cpu_wait + 5'd1;
    end else begin
      r_cpu_wait <= r_cpu_wait;
    end
  end
`else
  assign w_cpu_force = 1'b0;
`endif

  // Access FSM: grant latches the request, ACC drives the SRAM strobes, the last cycle
  // captures read data and schedules the winner's ack for the following (IDLE) cycle.
  always_ff @(posedge clk40m or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_grant_id  <= ID_NONE;
      r_mem_a     <= 14'd0;
      r_mem_dout  <= 8'd0;
      r_mem_rdata <= 8'd0;
      r_mem_we_n  <= 1'b1;
      r_mem_oe_n  <= 1'b1;
      r_vid_ack   <= 1'b0;
      r_spr_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_spr_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win != ID_NONE) begin
            r_state    <= ST_ACC;
            r_grant_id <= w_win;
            r_mem_a    <= w_win_a;
            r_mem_dout <= w_win_wdata;
            r_wr       <= w_win_wr;
            r_cnt      <= CNT_LOAD;
            r_mem_oe_n <= w_win_wr;
            r_mem_we_n <= ~w_win_wr;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (r_cnt == 4'd0) begin
            r_state    <= ST_IDLE;
            r_mem_oe_n <= 1'b1;
            r_mem_we_n <= 1'b1;
            if (!r_wr) begin
              r_mem_rdata <= mem_din;
            end else begin
              r_mem_rdata <= r_mem_rdata;
            end
            case (r_grant_id)
              ID_VID:  r_vid_ack <= 1'b1;
              ID_SPR:  r_spr_ack <= 1'b1;
              ID_CPU:  r_cpu_ack <= 1'b1;
              default: r_vid_ack <= 1'b0;
            endcase
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Release WE one cycle early so address and data are held past the strobe.
            if (r_cnt == 4'd1) begin
              r_mem_we_n <= 1'b1;
            end else begin
              r_mem_we_n <= r_mem_we_n;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vid_ack      = r_vid_ack;
  assign spr_ack      = r_spr_ack;
  assign vram_cpu_ack = r_cpu_ack;
  assign mem_rdata    = r_mem_rdata;
  assign mem_a        = r_mem_a;
  assign mem_dout     = r_mem_dout;
  assign mem_we_n     = r_mem_we_n;
  assign mem_oe_n     = r_mem_oe_n;
  assign grant_id     = r_grant_id;

endmodule
